bios_loader: RTL and testbench
==============================

BIOS_LOADER -- requirements
Module: bios_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 16-bit words buffered (power of two, 2..16).
REQ-002 clk  in  1  system clock; the same clock as the SDRAM controller; one clock domain; all logic on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 sync  in  1  frame strobe; the same signal the SDRAM controller receives; a rising edge starts an 8-cycle access frame.
REQ-005 dl_active  in  1  MCU download in progress.
REQ-006 dl_wr  in  1  single-cycle byte-valid strobe.
REQ-007 dl_data  in  8  download byte.
REQ-008 dl_ready  out  1  high when the FIFO can accept a completed word.
REQ-009 bios_addr  out  11  word address to the SDRAM BIOS port.
REQ-010 bios_din  out  16  word data to the SDRAM BIOS port.
REQ-011 bios_we  out  1  BIOS write request, held for one full frame.
REQ-012 cpu_hold  out  1  requests the chipset to keep oe/we low, because the main port has priority over the BIOS port.
REQ-013 done  out  1  one-cycle pulse when the download has been fully written.
REQ-014 overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-015 overflow  out  1  sticky flag: a word was dropped because it lay beyond address 2047.

Function
REQ-016 Byte packing shall be little-endian: the even byte goes to [7:0] and the odd byte to [15:8]; the word is pushed into the FIFO in the cycle the odd byte is accepted.
REQ-017 Frame-start detection shall be sync high while sync was low on the previous clock (registered old_sync).
REQ-018 The writer FSM shall have the states IDLE, ARM, WRITE and FLUSH.
REQ-019 IDLE -> ARM when the FIFO is non-empty.
REQ-020 ARM -> WRITE on frame start: pop the FIFO head, register bios_din and bios_addr, and set bios_we=1 on the same edge, so that bios_we is stable at frame stage 1.
REQ-021 WRITE -> hold bios_we, bios_addr and bios_din unchanged until the next frame start, then clear bios_we and increment the address.
REQ-022 After WRITE, the FSM shall go to ARM if the FIFO is non-empty, otherwise to IDLE.
REQ-023 Back-to-back words shall therefore occupy alternate frames, so that bios_we shows a low edge between writes.
REQ-024 A dl_active falling edge with an odd byte pending shall push {8'h00, byte}.
REQ-025 After a dl_active falling edge the FSM shall enter FLUSH, drain the FIFO through the normal ARM/WRITE path, then pulse done for one cycle and return to IDLE.
REQ-026 A dl_active rising edge shall clear the following: address to 0, byte phase, overrun, overflow and the FIFO; any in-flight WRITE shall complete its frame first.
REQ-027 dl_ready shall be low when the FIFO holds FIFO_DEPTH words.
REQ-028 A dl_wr odd byte arriving while the FIFO is full shall be dropped and shall set overrun; the byte phase shall still toggle.
REQ-029 Simultaneous push and pop while the FIFO is full shall be accepted.
REQ-030 The address counter shall be 12 bits; a word whose address is >= 2048 shall not be written (bios_we stays 0), shall set overflow, and shall still be popped.
REQ-031 dl_wr while dl_active=0 shall be ignored.
REQ-032 cpu_hold shall be high whenever dl_active=1, the FIFO is non-empty, or the FSM is not IDLE.
REQ-033 done and a new dl_active rising edge in the same cycle: done shall be issued first, and the clear shall take effect on the next cycle.

Reset
REQ-034 While reset_n=0 the block shall hold: bios_we=0, bios_addr=0, bios_din=0, cpu_hold=0, done=0, overrun=0, overflow=0, dl_ready=1, FIFO empty, byte phase even, FSM in IDLE, old_sync=0.
REQ-035 Reset asserted mid-WRITE shall drop bios_we asynchronously; the pending word is lost.
REQ-036 After reset deassertion, no write shall occur before the first frame start that follows a push.

Verification
REQ-037 Bytes 0x34,0x12,0x78,0x56 with sync every 8 clocks -> two frames with bios_we=1, carrying (addr 0, 0x1234) then (addr 1, 0x5678), separated by a bios_we-low frame; then done after dl_active falls.
REQ-038 Three bytes 0xAA,0xBB,0xCC, then dl_active falls -> words 0xBBAA@0 and 0x00CC@1; done pulses exactly once.
REQ-039 Burst of 20 bytes in 20 consecutive clocks with FIFO_DEPTH=4 -> dl_ready falls; overrun=1; the words written are exactly the first accepted words, with contiguous addresses.
REQ-040 Write 2049 words -> address 2047 is written; the 2049th word produces no bios_we; overflow=1; done still pulses.
REQ-041 reset_n pulsed low during WRITE -> bios_we=0 within the same cycle; after release all outputs hold their reset values until a new push arrives.
REQ-042 bios_we/bios_addr/bios_din sampled on the cycle after each frame start -> equal to the values registered at ARM->WRITE, throughout all scenarios.

Source files
------------

// File: rtl/bios_loader.sv
// BIOS download loader: packs MCU download bytes into 16-bit words, buffers them,
// and writes one word per alternate SDRAM frame through the BIOS port.
module bios_loader #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sync,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [7:0]  dl_data,
    output logic        dl_ready,
    output logic [10:0] bios_addr,
    output logic [15:0] bios_din,
    output logic        bios_we,
    output logic        cpu_hold,
    output logic        done,
    output logic        overrun,
    output logic        overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, WRITE, FLUSH} state_t;

    state_t        state, state_nxt, rest_state;
    logic          old_sync, old_active, phase, flush_pend, clear_pend;
    logic [7:0]    lo_byte;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [11:0]   addr;

    logic          frame_start, dl_rise, dl_fall, do_clear;
    logic          fifo_empty, fifo_full;
    logic          byte_ok, push_req, push;
    logic [15:0]   push_word;
    logic          pop, start_write, end_write, drop_word, done_set;

    assign frame_start = sync & ~old_sync;
    assign dl_rise     = dl_active & ~old_active;
    assign dl_fall     = ~dl_active & old_active;
    // A new download's clear is deferred until the current write frame has finished
    assign do_clear    = (dl_rise | clear_pend) & (state != WRITE);

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == FULL_COUNT);
    assign dl_ready    = ~fifo_full;

    assign byte_ok     = dl_active & dl_wr & ~do_clear;
    assign push_req    = ((byte_ok | dl_fall) & phase) & ~do_clear;
    assign push_word   = byte_ok ? {dl_data, lo_byte} : {8'h00, lo_byte};
    assign push        = push_req & (~fifo_full | pop);

    assign rest_state  = flush_pend ? FLUSH : IDLE;
    assign cpu_hold    = reset_n & (dl_active | ~fifo_empty | (state != IDLE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        start_write = 1'b0;
        end_write   = 1'b0;
        drop_word   = 1'b0;
        done_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty)     state_nxt = ARM;
                else if (flush_pend) state_nxt = FLUSH;
            end
            ARM: begin
                if (!do_clear) begin
                    if (fifo_empty) begin
                        state_nxt = rest_state;
                    end else if (frame_start) begin
                        pop = 1'b1;
                        if (addr[11]) begin
                            // Beyond the BIOS window: consume the word without a write frame
                            drop_word = 1'b1;
                            state_nxt = (count > CW'(1)) ? ARM : rest_state;
                        end else begin
                            start_write = 1'b1;
                            state_nxt   = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                if (frame_start) begin
                    end_write = 1'b1;
                    state_nxt = fifo_empty ? rest_state : ARM;
                end
            end
            FLUSH: begin
                if (!fifo_empty) begin
                    state_nxt = ARM;
                end else begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            old_sync   <= 1'b0;
            old_active <= 1'b0;
            phase      <= 1'b0;
            lo_byte    <= '0;
            flush_pend <= 1'b0;
            clear_pend <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            addr       <= '0;
            bios_addr  <= '0;
            bios_din   <= '0;
            bios_we    <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            old_sync   <= sync;
            old_active <= dl_active;
            done       <= done_set;
            flush_pend <= dl_fall | (flush_pend & ~done_set);
            clear_pend <= (dl_rise | clear_pend) & ~do_clear;

            if (do_clear || dl_fall) phase <= 1'b0;
            else if (byte_ok)        phase <= ~phase;
            if (byte_ok && !phase) lo_byte <= dl_data;

            if (do_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                addr     <= '0;
                overrun  <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (end_write)          addr     <= addr + 12'd1;
                if (push_req && !push)  overrun  <= 1'b1;
                if (drop_word)          overflow <= 1'b1;
            end

            if (start_write) begin
                bios_we   <= 1'b1;
                bios_addr <= addr[10:0];
                bios_din  <= fifo_mem[rd_ptr];
            end else if (end_write) begin
                bios_we   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bios_loader.sv
// Self-checking bench for bios_loader: random downloads checked against a
// byte-to-word model, plus burst/overrun, address overflow and reset cases.
module tb_bios_loader;

    logic        clk, reset_n, sync, dl_active, dl_wr;
    logic [7:0]  dl_data;
    logic        dl_ready, bios_we, cpu_hold, done, overrun, overflow;
    logic [10:0] bios_addr;
    logic [15:0] bios_din;

    bios_loader #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .sync(sync), .dl_active(dl_active),
        .dl_wr(dl_wr), .dl_data(dl_data), .dl_ready(dl_ready),
        .bios_addr(bios_addr), .bios_din(bios_din), .bios_we(bios_we),
        .cpu_hold(cpu_hold), .done(done), .overrun(overrun), .overflow(overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic fs_edge, sync_prev;
    logic [26:0] caps [$];
    logic [7:0]  bq [$];
    logic [15:0] ew [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Frame strobe: one clock high every 8 clocks; fs_edge marks the edge the DUT sees it on
    initial begin
        sync = 1'b0; sync_prev = 1'b0; fs_edge = 1'b0;
        forever begin
            @(posedge clk);
            fs_edge   = sync && !sync_prev;
            sync_prev = sync;
            cyc++;
            #1 sync = (cyc % 8 == 0);
        end
    end

    logic        we_prev = 1'b0, done_prev = 1'b0, have_last = 1'b0;
    logic [10:0] cap_addr;
    logic [15:0] cap_din;
    int          high_len = 0, last_rise = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_we_low", 32'(bios_we), 32'd0);
            we_prev = 1'b0; done_prev = 1'b0; have_last = 1'b0; high_len = 0;
        end else begin
            if (bios_we && !we_prev) begin
                check("we_rise_on_frame", 32'(fs_edge), 32'd1);
                if (have_last) check("we_alt_frames", 32'(cyc - last_rise >= 16), 32'd1);
                have_last = 1'b1; last_rise = cyc;
                cap_addr = bios_addr; cap_din = bios_din; high_len = 1;
                caps.push_back({bios_addr, bios_din});
            end else if (bios_we && we_prev) begin
                check("we_hold_addr", 32'(bios_addr), 32'(cap_addr));
                check("we_hold_din", 32'(bios_din), 32'(cap_din));
                high_len++;
            end else if (!bios_we && we_prev) begin
                check("we_fall_on_frame", 32'(fs_edge), 32'd1);
                check("we_frame_len", 32'(high_len), 32'd8);
            end
            we_prev = bios_we;
            if (done) begin
                check("done_one_cycle", 32'(done_prev), 32'd0);
                done_cnt++;
            end
            done_prev = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int budget = 200;
        while (dl_ready !== 1'b1 && budget > 0) begin
            tick(1);
            budget--;
        end
        check("ready_wait", 32'(dl_ready), 32'd1);
    endtask

    task automatic start_dl();
        caps.delete();
        dl_active = 1'b1;
        tick(2);
        check("hold_during_dl", 32'(cpu_hold), 32'd1);
    endtask

    task automatic send_all(input int maxgap);
        for (int i = 0; i < bq.size(); i++) begin
            if (i % 2 == 1) wait_ready();
            dl_wr = 1'b1; dl_data = bq[i];
            tick(1);
            dl_wr = 1'b0;
            if (maxgap > 0) tick($urandom_range(maxgap, 0));
        end
    endtask

    // Reference: little-endian pairs, a trailing odd byte zero-extended
    task automatic build_words();
        ew.delete();
        for (int i = 0; i < bq.size(); i += 2)
            ew.push_back((i + 1 < bq.size()) ? {bq[i+1], bq[i]} : {8'h00, bq[i]});
    endtask

    task automatic end_dl(input int budget);
        int d0 = done_cnt;
        dl_active = 1'b0;
        while (done_cnt == d0 && budget > 0) begin
            tick(1);
            budget--;
        end
        tick(24);
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("idle_hold_low", 32'(cpu_hold), 32'd0);
    endtask

    task automatic expect_writes(input string tag, input int n);
        int bad = 0;
        check({tag, "_count"}, 32'(caps.size()), 32'(n));
        for (int i = 0; i < n && i < caps.size(); i++)
            if (caps[i] !== {11'(i), ew[i]}) bad++;
        check({tag, "_words"}, 32'(bad), 32'd0);
    endtask

    task automatic random_dl(input string tag, input int nbytes, input int maxgap);
        bq.delete();
        repeat (nbytes) bq.push_back(8'($urandom));
        build_words();
        start_dl();
        send_all(maxgap);
        end_dl(400);
        expect_writes(tag, ew.size());
    endtask

    initial begin
        int n, j, bad, d0, budget;
        logic saw_low;

        reset_n = 1'b0; dl_active = 1'b1; dl_wr = 1'b0; dl_data = '0;
        tick(3);
        @(negedge clk);
        check("rst_addr", 32'(bios_addr), 32'd0);
        check("rst_din", 32'(bios_din), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ready", 32'(dl_ready), 32'd1);
        dl_active = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(2);

        bq = '{8'h34, 8'h12, 8'h78, 8'h56};
        ew = '{16'h1234, 16'h5678};
        start_dl();
        send_all(1);
        end_dl(400);
        expect_writes("basic", 2);

        bq = '{8'hAA, 8'hBB, 8'hCC};
        ew = '{16'hBBAA, 16'h00CC};
        start_dl();
        send_all(0);
        end_dl(400);
        expect_writes("odd_tail", 2);
        check("odd_tail_no_overrun", 32'(overrun), 32'd0);

        for (int r = 0; r < 4; r++)
            random_dl("rand", $urandom_range(12, 1), 3);

        // Burst of 20 bytes in consecutive clocks, no flow control
        bq.delete();
        repeat (20) bq.push_back(8'($urandom));
        build_words();
        start_dl();
        saw_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            dl_wr = 1'b1; dl_data = bq[i];
            tick(1);
            if (dl_ready === 1'b0) saw_low = 1'b1;
        end
        dl_wr = 1'b0;
        check("burst_ready_low", 32'(saw_low), 32'd1);
        check("burst_overrun", 32'(overrun), 32'd1);
        end_dl(400);
        check("burst_overrun_sticky", 32'(overrun), 32'd1);
        n = caps.size();
        check("burst_min_words", 32'(n >= 4), 32'd1);
        check("burst_some_dropped", 32'(n < 10), 32'd1);
        bad = 0; j = 4;
        for (int i = 0; i < n; i++) begin
            if (caps[i][26:16] !== 11'(i)) bad++;
            if (i < 4) begin
                if (caps[i][15:0] !== ew[i]) bad++;
            end else begin
                while (j < ew.size() && ew[j] !== caps[i][15:0]) j++;
                if (j >= ew.size()) bad++;
                j++;
            end
        end
        check("burst_accepted_order", 32'(bad), 32'd0);

        start_dl();
        check("rise_clears_overrun", 32'(overrun), 32'd0);
        dl_active = 1'b0;
        tick(1);
        end_dl(100);
        random_dl("after_burst", 6, 2);

        // 2049 words: the last one lies beyond the BIOS window
        bq.delete();
        repeat (4098) bq.push_back(8'($urandom));
        build_words();
        start_dl();
        for (int i = 0; i < 4000; i++) begin
            if (i % 2 == 1) wait_ready();
            dl_wr = 1'b1; dl_data = bq[i];
            tick(1);
            dl_wr = 1'b0;
        end
        check("ovf_not_yet", 32'(overflow), 32'd0);
        for (int i = 4000; i < 4098; i++) begin
            if (i % 2 == 1) wait_ready();
            dl_wr = 1'b1; dl_data = bq[i];
            tick(1);
            dl_wr = 1'b0;
        end
        end_dl(1000);
        expect_writes("ovf", 2048);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_last_addr", 32'(caps[caps.size()-1][26:16]), 32'd2047);
        start_dl();
        check("rise_clears_overflow", 32'(overflow), 32'd0);
        dl_active = 1'b0;
        tick(1);
        end_dl(100);

        // Reset during a write frame
        bq = '{8'h11, 8'h22};
        start_dl();
        send_all(0);
        budget = 100;
        while (bios_we !== 1'b1 && budget > 0) begin
            tick(1);
            budget--;
        end
        check("rst_test_we_seen", 32'(bios_we), 32'd1);
        tick(2);
        #2 reset_n = 1'b0;
        #1 check("rst_async_we", 32'(bios_we), 32'd0);
        dl_active = 1'b0;
        tick(3);
        check("rst_mid_addr", 32'(bios_addr), 32'd0);
        check("rst_mid_ready", 32'(dl_ready), 32'd1);
        caps.delete();
        d0 = done_cnt;
        reset_n = 1'b1;
        tick(40);
        check("post_rst_no_write", 32'(caps.size()), 32'd0);
        check("post_rst_we", 32'(bios_we), 32'd0);
        check("post_rst_din", 32'(bios_din), 32'd0);
        check("post_rst_hold", 32'(cpu_hold), 32'd0);
        check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
        random_dl("post_rst", 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
